// File: rtl/g_inverse_engine_if.sv
// Handshake bundle for the G inverse engine: post-G quadruple and message
// words in, recovered pre-G quadruple out.
interface g_inverse_engine_if #(
   parameter int W = 32
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a_in;
   logic [W-1:0] b_in;
   logic [W-1:0] c_in;
   logic [W-1:0] d_in;
   logic [W-1:0] x;
   logic [W-1:0] y;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] a_out;
   logic [W-1:0] b_out;
   logic [W-1:0] c_out;
   logic [W-1:0] d_out;

   // Producer/consumer side that feeds the engine and takes its results.
   modport master (
      output in_valid, a_in, b_in, c_in, d_in, x, y, out_ready,
      input  in_ready, out_valid, a_out, b_out, c_out, d_out
   );

   // The engine itself.
   modport slave (
      input  in_valid, a_in, b_in, c_in, d_in, x, y, out_ready,
      output in_ready, out_valid, a_out, b_out, c_out, d_out
   );
endinterface

// File: rtl/g_inverse_engine.sv
// Iterative inverse of the BLAKE2 G mixing function. One shared inverse
// half-step datapath undoes the second forward half (y, R3, R4) and then the
// first forward half (x, R1, R2).
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | in_ready high, waiting for a quadruple to accept
// H2    | undo second forward half-G using y, R3 (d), R4 (b)
// H1    | undo first forward half-G using x, R1 (d), R2 (b)
// DONE  | out_valid high, result held until out_ready
//
// R1..R4 must each lie in 1..W-1.
module g_inverse_engine #(
   parameter int W  = 32,
   parameter int R1 = 16,
   parameter int R2 = 12,
   parameter int R3 = 8,
   parameter int R4 = 7
) (
   input  logic                clk,
   input  logic                rst_n,
   g_inverse_engine_if.slave   bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_H2   = 2'd1,
      S_H1   = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t       state_q, state_d;
   logic [W-1:0] a_q, b_q, c_q, d_q;
   logic [W-1:0] a_d, b_d, c_d, d_d;
   logic [W-1:0] x_q, y_q;
   logic [W-1:0] x_d, y_d;

   logic [W-1:0] m_sel, b_rot, d_rot;
   logic [W-1:0] ha, hb, hc, hd;

   function automatic logic [W-1:0] rotl(input logic [W-1:0] v, input int r);
      return (v << r) | (v >> (W - r));
   endfunction

   // Shared inverse half-step; the rotation pair and message word are
   // selected by which half is being undone.
   always_comb begin
      m_sel = x_q;
      b_rot = rotl(b_q, R2);
      d_rot = rotl(d_q, R1);
      if (state_q == S_H2) begin
         m_sel = y_q;
         b_rot = rotl(b_q, R4);
         d_rot = rotl(d_q, R3);
      end
      hb = b_rot ^ c_q;
      hc = c_q - d_q;
      hd = d_rot ^ a_q;
      ha = a_q - hb - m_sel;
   end

   // Next-state and working-register update.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      d_d     = d_q;
      x_d     = x_q;
      y_d     = y_q;
      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               a_d     = bus.a_in;
               b_d     = bus.b_in;
               c_d     = bus.c_in;
               d_d     = bus.d_in;
               x_d     = bus.x;
               y_d     = bus.y;
               state_d = S_H2;
            end
         end
         S_H2: begin
            a_d     = ha;
            b_d     = hb;
            c_d     = hc;
            d_d     = hd;
            state_d = S_H1;
         end
         S_H1: begin
            a_d     = ha;
            b_d     = hb;
            c_d     = hc;
            d_d     = hd;
            state_d = S_DONE;
         end
         S_DONE: begin
            if (bus.out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset clears everything so the outputs
   // read zero immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         d_q     <= '0;
         x_q     <= '0;
         y_q     <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         d_q     <= d_d;
         x_q     <= x_d;
         y_q     <= y_d;
      end
   end

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.out_valid = (state_q == S_DONE);
   assign bus.a_out     = a_q;
   assign bus.b_out     = b_q;
   assign bus.c_out     = c_q;
   assign bus.d_out     = d_q;

endmodule
